// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response bundle between two ALU requesters and the shared-ALU arbiter
//   req0_*/req1_* : request channels (valid/ready accept, op, signed operands a/b)
//   rsp_*         : registered response channel (valid/ready, requester id, result, flags)
//   busy          : arbiter is not idle
interface alu_share_arbiter_if #(parameter int W = 64);
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_of, rsp_zf, rsp_sf, busy;
    logic [W-1:0] rsp_res;
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_res, rsp_of, rsp_zf, rsp_sf, busy
    );
    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b, rsp_ready,
        output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_res, rsp_of, rsp_zf, rsp_sf, busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one 64-bit ALU between two requesters
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_share_arbiter_if.slave (two request channels, one response channel, busy)
module alu_64 #(parameter int W = 64) (
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         of,
    output logic         zf,
    output logic         sf
);
    always_comb begin
        res = op == 2'd0 ? a + b : op == 2'd1 ? a - b : op == 2'd2 ? a & b : a ^ b;
        of  = op == 2'd0 ? (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]) :
              op == 2'd1 ? (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]) : 1'b0;
        zf  = res == '0;
        sf  = res[W-1];
    end
endmodule

module alu_share_arbiter #(parameter int W = 64) (
    input logic              clk,
    input logic              rst,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t       state;
    logic         pri, id_r, g0, g1, alu_of, alu_zf, alu_sf;
    logic [1:0]   op_r;
    logic [W-1:0] a_r, b_r, alu_res;
    // Single valid wins outright; on contention the port named by pri wins.
    assign g0 = state == IDLE && bus.req0_valid && (!bus.req1_valid || !pri);
    assign g1 = state == IDLE && bus.req1_valid && (!bus.req0_valid || pri);
    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    alu_64 #(.W(W)) u_alu (
        .op(op_r), .a(a_r), .b(b_r), .res(alu_res), .of(alu_of), .zf(alu_zf), .sf(alu_sf)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            pri           <= 1'b0;
            id_r          <= 1'b0;
            op_r          <= '0;
            a_r           <= '0;
            b_r           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_res   <= '0;
            bus.rsp_of    <= 1'b0;
            bus.rsp_zf    <= 1'b0;
            bus.rsp_sf    <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (g0 || g1) begin
                    op_r     <= g1 ? bus.req1_op : bus.req0_op;
                    a_r      <= g1 ? bus.req1_a : bus.req0_a;
                    b_r      <= g1 ? bus.req1_b : bus.req0_b;
                    id_r     <= g1;
                    pri      <= !g1;  // loser gets priority next time, even if it was idle
                    bus.busy <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    bus.rsp_res   <= alu_res;
                    bus.rsp_of    <= alu_of;
                    bus.rsp_zf    <= alu_zf;
                    bus.rsp_sf    <= alu_sf;
                    bus.rsp_id    <= id_r;
                    bus.rsp_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the shared-ALU arbiter
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    always #5 clk = ~clk;
    alu_share_arbiter_if #(.W(64)) bus();
    alu_share_arbiter #(.W(64)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_op = 0; bus.req1_op = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0; bus.rsp_ready = 1;
    endtask

    // Presents one request on port p, drops it after the accept edge, returns in the first DONE cycle.
    task automatic issue(input bit p, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        if (p) begin bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1; end
        else begin bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1; end
        tick;
        bus.req0_valid = 0; bus.req1_valid = 0;
        tick;
    endtask

    function automatic void alu_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic o);
        logic [64:0] s;
        s = op == 2'd1 ? {a[63], a} - {b[63], b} : {a[63], a} + {b[63], b};
        r = op == 2'd2 ? a & b : op == 2'd3 ? a ^ b : s[63:0];
        o = op[1] ? 1'b0 : s[64] != s[63];
    endfunction

    function automatic logic [63:0] rnd64;
        int k;
        k = $urandom_range(0, 5);
        return k == 0 ? 64'd0 : k == 1 ? MAXP : k == 2 ? MINN : k == 3 ? ONES :
               k == 4 ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
    endfunction

    task automatic test_reset;
        rst = 1; idle_inputs;
        tick; tick;
        rst = 0;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.rsp_res !== 64'd0) begin errors++; $display("FAIL reset_res: got %h expected 0", bus.rsp_res); end
        checks++; if ({bus.rsp_id, bus.rsp_of, bus.rsp_zf, bus.rsp_sf} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {bus.rsp_id, bus.rsp_of, bus.rsp_zf, bus.rsp_sf}); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready}); end
    endtask

    task automatic test_single;
        bus.rsp_ready = 1; bus.req0_op = 0; bus.req0_a = 11; bus.req0_b = 42; bus.req0_valid = 1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
        tick;
        bus.req0_valid = 0;
        checks++; if ({bus.busy, bus.rsp_valid} !== 2'b10) begin errors++; $display("FAIL single_exec: busy/valid got %b expected 10", {bus.busy, bus.rsp_valid}); end
        tick;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.rsp_valid); end
        checks++; if (bus.rsp_res !== 64'd53) begin errors++; $display("FAIL single_res: got %h expected %h", bus.rsp_res, 64'd53); end
        checks++; if ({bus.rsp_of, bus.rsp_zf, bus.rsp_sf, bus.rsp_id} !== 4'b0000) begin errors++; $display("FAIL single_flags: of/zf/sf/id got %b expected 0000", {bus.rsp_of, bus.rsp_zf, bus.rsp_sf, bus.rsp_id}); end
        tick;
        checks++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin errors++; $display("FAIL single_idle: busy/valid got %b expected 00", {bus.busy, bus.rsp_valid}); end
    endtask

    task automatic test_backpressure;
        bus.rsp_ready = 0; bus.req1_op = 2; bus.req1_a = 11; bus.req1_b = 42; bus.req1_valid = 1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("FAIL bp_ready: got %b expected 01", {bus.req0_ready, bus.req1_ready}); end
        tick;
        bus.req1_valid = 0;
        tick;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({bus.rsp_valid, bus.busy, bus.rsp_id} !== 3'b111 || bus.rsp_res !== 64'd10) begin errors++; $display("FAIL bp_hold%0d: valid/busy/id=%b res=%h expected 111 res=%h", i, {bus.rsp_valid, bus.busy, bus.rsp_id}, bus.rsp_res, 64'd10); end
            tick;
        end
        bus.rsp_ready = 1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", bus.rsp_valid); end
        tick;
        checks++; if ({bus.busy, bus.rsp_valid} !== 2'b00) begin errors++; $display("FAIL bp_idle: busy/valid got %b expected 00", {bus.busy, bus.rsp_valid}); end
    endtask

    task automatic test_alternate;
        bus.rsp_ready = 1;
        bus.req0_op = 1; bus.req0_a = 5; bus.req0_b = 5;
        bus.req1_op = 3; bus.req1_a = ONES; bus.req1_b = 0;
        bus.req0_valid = 1; bus.req1_valid = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({bus.req0_ready, bus.req1_ready} !== (k % 2 == 0 ? 2'b10 : 2'b01)) begin errors++; $display("FAIL alt_grant%0d: got %b expected %b", k, {bus.req0_ready, bus.req1_ready}, (k % 2 == 0 ? 2'b10 : 2'b01)); end
            tick; tick;
            if (k % 2 == 0) begin
                checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zf, bus.rsp_sf} !== 4'b1010 || bus.rsp_res !== 64'd0) begin errors++; $display("FAIL alt_rsp%0d: valid/id/zf/sf=%b res=%h expected 1010 res=0", k, {bus.rsp_valid, bus.rsp_id, bus.rsp_zf, bus.rsp_sf}, bus.rsp_res); end
            end else begin
                checks++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_zf, bus.rsp_sf} !== 4'b1101 || bus.rsp_res !== ONES) begin errors++; $display("FAIL alt_rsp%0d: valid/id/zf/sf=%b res=%h expected 1101 res=%h", k, {bus.rsp_valid, bus.rsp_id, bus.rsp_zf, bus.rsp_sf}, bus.rsp_res, ONES); end
            end
            if (k == 3) begin bus.req0_valid = 0; bus.req1_valid = 0; end
            tick;
        end
    endtask

    task automatic test_overflow;
        bus.rsp_ready = 1;
        issue(0, 2'd0, MAXP, 64'd1);
        checks++; if ({bus.rsp_valid, bus.rsp_of, bus.rsp_sf} !== 3'b111 || bus.rsp_res !== MINN) begin errors++; $display("FAIL ovf_add: valid/of/sf=%b res=%h expected 111 res=%h", {bus.rsp_valid, bus.rsp_of, bus.rsp_sf}, bus.rsp_res, MINN); end
        tick;
        issue(1, 2'd1, MINN, 64'd1);
        checks++; if ({bus.rsp_valid, bus.rsp_of, bus.rsp_sf} !== 3'b110 || bus.rsp_res !== MAXP) begin errors++; $display("FAIL ovf_sub: valid/of/sf=%b res=%h expected 110 res=%h", {bus.rsp_valid, bus.rsp_of, bus.rsp_sf}, bus.rsp_res, MAXP); end
        tick;
        issue(0, 2'd3, MAXP, ONES);
        checks++; if ({bus.rsp_valid, bus.rsp_of, bus.rsp_sf} !== 3'b101 || bus.rsp_res !== MINN) begin errors++; $display("FAIL ovf_xor: valid/of/sf=%b res=%h expected 101 res=%h", {bus.rsp_valid, bus.rsp_of, bus.rsp_sf}, bus.rsp_res, MINN); end
        tick;
    endtask

    task automatic test_latch;
        bus.rsp_ready = 1; bus.req0_op = 0; bus.req0_a = 100; bus.req0_b = 23; bus.req0_valid = 1;
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL latch_ready: got %b expected 1", bus.req0_ready); end
        tick;
        bus.req0_valid = 0; bus.req0_a = ONES; bus.req0_b = ONES; bus.req0_op = 3;
        tick;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_res !== 64'd123) begin errors++; $display("FAIL latch_res: valid=%b res=%h expected 1 res=%h", bus.rsp_valid, bus.rsp_res, 64'd123); end
        tick;
    endtask

    task automatic test_reset_mid;
        bus.rsp_ready = 1; bus.req0_op = 0; bus.req0_a = 1; bus.req0_b = 2; bus.req0_valid = 1;
        tick;
        bus.req0_valid = 0; rst = 1;
        tick;
        rst = 0;
        checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00) begin errors++; $display("FAIL rst_exec_state: valid/busy got %b expected 00", {bus.rsp_valid, bus.busy}); end
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL rst_exec_pri: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
        bus.req0_valid = 0; bus.req1_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_exec_norsp%0d: got %b expected 0", i, bus.rsp_valid); end
        end
        bus.rsp_ready = 0;
        issue(0, 2'd0, 64'd1, 64'd2);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rst_done_pre: got %b expected 1", bus.rsp_valid); end
        bus.rsp_ready = 1; rst = 1;
        tick;
        rst = 0;
        checks++; if ({bus.rsp_valid, bus.busy} !== 2'b00 || bus.rsp_res !== 64'd0) begin errors++; $display("FAIL rst_done_state: valid/busy=%b res=%h expected 00 res=0", {bus.rsp_valid, bus.busy}, bus.rsp_res); end
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL rst_done_pri: got %b expected 10", {bus.req0_ready, bus.req1_ready}); end
        bus.req0_valid = 0; bus.req1_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_done_norsp%0d: got %b expected 0", i, bus.rsp_valid); end
        end
    endtask

    task automatic test_random;
        bit pend0 = 0, pend1 = 0, mpri = 0, eo = 0, eid = 0;
        logic [1:0] op0 = 0, op1 = 0;
        logic [63:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0, er = 0;
        logic g0, g1;
        int ms = 0, ops = 0;
        rst = 1; idle_inputs;
        tick;
        rst = 0;
        for (int cyc = 0; cyc < 20000 && ops < 1000; cyc++) begin
            if (!pend0 && $urandom_range(0, 1) == 1) begin pend0 = 1; op0 = 2'($urandom_range(0, 3)); a0 = rnd64(); b0 = rnd64(); end
            if (!pend1 && $urandom_range(0, 1) == 1) begin pend1 = 1; op1 = 2'($urandom_range(0, 3)); a1 = rnd64(); b1 = rnd64(); end
            bus.req0_valid = pend0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
            bus.req1_valid = pend1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
            bus.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            g0 = ms == 0 && pend0 && (!pend1 || !mpri);
            g1 = ms == 0 && pend1 && (!pend0 || mpri);
            checks++; if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin errors++; $display("FAIL rnd_grant cyc%0d: got %b expected %b", cyc, {bus.req0_ready, bus.req1_ready}, {g0, g1}); end
            checks++; if ({bus.rsp_valid, bus.busy} !== {ms == 2, ms != 0}) begin errors++; $display("FAIL rnd_state cyc%0d: valid/busy got %b expected %b", cyc, {bus.rsp_valid, bus.busy}, {ms == 2, ms != 0}); end
            if (ms == 2) begin
                checks++; if ({bus.rsp_id, bus.rsp_of, bus.rsp_zf, bus.rsp_sf} !== {eid, eo, er == 64'd0, er[63]} || bus.rsp_res !== er) begin errors++; $display("FAIL rnd_rsp cyc%0d: id/of/zf/sf=%b res=%h expected %b res=%h", cyc, {bus.rsp_id, bus.rsp_of, bus.rsp_zf, bus.rsp_sf}, bus.rsp_res, {eid, eo, er == 64'd0, er[63]}, er); end
            end
            if (ms == 0 && (g0 || g1)) begin
                if (g1) alu_ref(op1, a1, b1, er, eo); else alu_ref(op0, a0, b0, er, eo);
                eid = g1; mpri = !g1; ms = 1; ops++;
                if (g1) pend1 = 0; else pend0 = 0;
            end else if (ms == 1) ms = 2;
            else if (ms == 2 && bus.rsp_ready) ms = 0;
            tick;
        end
        checks++; if (ops < 1000) begin errors++; $display("FAIL rnd_budget: got %0d ops expected 1000", ops); end
    endtask

    initial begin
        idle_inputs;
        test_reset;
        test_single;
        test_backpressure;
        test_alternate;
        test_overflow;
        test_latch;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
